wb_cmd_initiator: RTL and testbench

Single-transaction Wishbone classic bus master. It accepts read/write commands on a valid/ready command port, runs one Wishbone cycle per command against peripheral slaves on the same bus (counter/timers, GPIO, etc.), and returns the read data and an error flag on a valid/ready response port. A cycle-count timeout aborts transactions that a slave never acknowledges. It is the initiator end of the bus the counter/timer register blocks respond on.

---
 rtl/wb_cmd_initiator.sv | 148 ++++++++++++++
 tb/tb_wb_cmd_initiator.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_initiator.sv
// Single-outstanding Wishbone classic master: one bus cycle per command,
// response returned on a valid/ready port, with an optional no-ack timeout.
module wb_cmd_initiator #(
  parameter int unsigned     TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(255)
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i
);

  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);
  localparam bit              TO_EN   = (TIMEOUT != '0);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_e;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_dat_q, rsp_dat_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [3:0]      sel_q, sel_d;
  logic            we_q, we_d;
  logic            stb_q, stb_d;
  logic            to_hit;

  // Abort on the last permitted strobe cycle unless an ack arrives in it.
  assign to_hit = TO_EN && (cnt_q == TO_LAST);

  // Ready is a state decode, held low for the whole reset assertion.
  assign cmd_ready = (state_q == ST_IDLE) && !wb_rst_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_valid)            state_d = ST_BUS;
      ST_BUS:  if (wb_ack_i || to_hit)   state_d = ST_RESP;
      ST_RESP: if (rsp_ready)            state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    stb_d       = stb_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          adr_d = cmd_adr;
          dat_d = cmd_dat;
          sel_d = cmd_sel;
          we_d  = cmd_we;
          stb_d = 1'b1;
          cnt_d = '0;
        end
      end
      ST_BUS: begin
        if (wb_ack_i) begin
          rsp_dat_d   = we_q ? 32'h0 : wb_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          stb_d       = 1'b0;
        end else if (to_hit) begin
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          stb_d       = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: begin
        rsp_valid_d = 1'b0;
        stb_d       = 1'b0;
      end
    endcase
  end

  // Single strobe flop drives both cyc and stb so they always move together.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'h0;
      rsp_err_q   <= 1'b0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      sel_q       <= 4'h0;
      we_q        <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      stb_q       <= stb_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = stb_q;
  assign wb_stb_o  = stb_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator: main instance TIMEOUT=8, second TIMEOUT=4.
module tb_wb_cmd_initiator;

  logic clk, rst;
  logic cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0] cmd_sel;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0] wb_sel_o;
  logic wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
  logic ack_man, ack_follow;

  logic cmd_valid2, cmd_ready2, cmd_we2;
  logic [31:0] cmd_adr2, cmd_dat2;
  logic [3:0] cmd_sel2;
  logic rsp_valid2, rsp_ready2, rsp_err2;
  logic [31:0] rsp_dat2;
  logic [31:0] wb_adr_o2, wb_dat_o2, wb_dat_i2;
  logic [3:0] wb_sel_o2;
  logic wb_we_o2, wb_cyc_o2, wb_stb_o2, wb_ack_i2;

  int total, bad;

  // Slave ack: either driven by the test or combinationally following stb.
  assign wb_ack_i = ack_man | (ack_follow & wb_stb_o);

  wb_cmd_initiator #(.TO_W(16), .TIMEOUT(16'd8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  wb_cmd_initiator #(.TO_W(16), .TIMEOUT(16'd4)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_we(cmd_we2),
    .cmd_adr(cmd_adr2), .cmd_dat(cmd_dat2), .cmd_sel(cmd_sel2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_dat(rsp_dat2), .rsp_err(rsp_err2),
    .wb_adr_o(wb_adr_o2), .wb_dat_o(wb_dat_o2), .wb_sel_o(wb_sel_o2), .wb_we_o(wb_we_o2),
    .wb_cyc_o(wb_cyc_o2), .wb_stb_o(wb_stb_o2), .wb_ack_i(wb_ack_i2), .wb_dat_i(wb_dat_i2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    total++;
    if ({rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o});
    end
    total++;
    if ({rsp_dat, wb_adr_o, wb_dat_o, wb_sel_o} !== 100'h0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", rsp_dat, wb_adr_o, wb_dat_o, wb_sel_o);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait;
    drive_cmd(1'b1, 32'h2400_0004, 32'hDEAD_BEEF, 4'hF);
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, cmd_ready} !==
        {3'b111, 32'h2400_0004, 32'hDEAD_BEEF, 4'hF, 1'b0}) begin
      bad++; $display("FAIL write_bus got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rdy=%b", wb_cyc_o,
                      wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, cmd_ready);
    end
    ack_man  = 1'b1;
    wb_dat_i = 32'hFFFF_FFFF;
    tick();
    ack_man = 1'b0;
    total++;
    if ({wb_cyc_o, wb_stb_o, rsp_valid, rsp_err, rsp_dat} !== {4'b0010, 32'h0}) begin
      bad++; $display("FAIL write_rsp got cyc=%b stb=%b v=%b err=%b dat=%h exp 0,0,1,0,0", wb_cyc_o, wb_stb_o,
                      rsp_valid, rsp_err, rsp_dat);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      bad++; $display("FAIL write_done got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_wait3;
    drive_cmd(1'b0, 32'h2400_0008, 32'hA5A5_A5A5, 4'h5);
    tick();
    cmd_valid = 1'b0;
    wb_dat_i  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, rsp_valid} !==
          {3'b110, 32'h2400_0008, 32'hA5A5_A5A5, 4'h5, 1'b0}) begin
        bad++; $display("FAIL read_wait_bus cyc%0d got cyc=%b stb=%b we=%b adr=%h sel=%h v=%b", i + 1,
                        wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, rsp_valid);
      end
      if (i == 3) begin
        ack_man  = 1'b1;
        wb_dat_i = 32'h1234_5678;
      end
      tick();
    end
    ack_man  = 1'b0;
    wb_dat_i = 32'h0;
    total++;
    if ({wb_stb_o, rsp_valid, rsp_err, rsp_dat} !== {3'b010, 32'h1234_5678}) begin
      bad++; $display("FAIL read_wait_rsp got stb=%b v=%b err=%b dat=%h exp 0,1,0,12345678", wb_stb_o,
                      rsp_valid, rsp_err, rsp_dat);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int n;
    drive_cmd(1'b0, 32'h2400_0000, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    wb_dat_i  = 32'hCAFE_F00D;
    n = 0;
    while (wb_stb_o === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    total++;
    if (n !== 8) begin bad++; $display("FAIL timeout_stb_cycles got=%0d exp=8", n); end
    total++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {2'b11, 32'h0}) begin
      bad++; $display("FAIL timeout_rsp got v=%b err=%b dat=%h exp 1,1,0", rsp_valid, rsp_err, rsp_dat);
    end
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    total++;
    if ({rsp_valid, rsp_err, rsp_dat, wb_stb_o} !== {2'b11, 32'h0, 1'b0}) begin
      bad++; $display("FAIL timeout_late_ack got v=%b err=%b dat=%h stb=%b", rsp_valid, rsp_err, rsp_dat,
                      wb_stb_o);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    ack_man   = 1'b1;
    tick();
    ack_man = 1'b0;
    total++;
    if ({cmd_ready, wb_cyc_o, rsp_valid} !== 3'b100) begin
      bad++; $display("FAIL idle_stray_ack got rdy=%b cyc=%b v=%b exp 1,0,0", cmd_ready, wb_cyc_o, rsp_valid);
    end
  endtask

  task automatic test_ack_on_expiry;
    int n;
    cmd_valid2 = 1'b1;
    cmd_we2    = 1'b0;
    cmd_adr2   = 32'h2400_0020;
    cmd_sel2   = 4'hF;
    tick();
    cmd_valid2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wb_stb_o2 !== 1'b1) begin bad++; $display("FAIL expiry_stb cyc%0d got=%b exp=1", i + 1, wb_stb_o2); end
      if (i == 3) begin
        wb_ack_i2 = 1'b1;
        wb_dat_i2 = 32'h0BAD_F00D;
      end
      tick();
    end
    wb_ack_i2 = 1'b0;
    total++;
    if ({rsp_valid2, rsp_err2, rsp_dat2} !== {2'b10, 32'h0BAD_F00D}) begin
      bad++; $display("FAIL expiry_ack_wins got v=%b err=%b dat=%h exp 1,0,0badf00d", rsp_valid2, rsp_err2,
                      rsp_dat2);
    end
    rsp_ready2 = 1'b1;
    tick();
    rsp_ready2 = 1'b0;
    cmd_valid2 = 1'b1;
    tick();
    cmd_valid2 = 1'b0;
    n = 0;
    while (wb_stb_o2 === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    total++;
    if ({n[7:0], rsp_err2} !== {8'd4, 1'b1}) begin
      bad++; $display("FAIL timeout4 got cycles=%0d err=%b exp 4,1", n, rsp_err2);
    end
    rsp_ready2 = 1'b1;
    tick();
    rsp_ready2 = 1'b0;
  endtask

  task automatic test_backpressure;
    drive_cmd(1'b0, 32'h2400_000C, 32'h0, 4'hF);
    tick();
    ack_man  = 1'b1;
    wb_dat_i = 32'h55AA_33CC;
    tick();
    ack_man  = 1'b0;
    wb_dat_i = 32'h0;
    drive_cmd(1'b1, 32'h2400_0010, 32'h1111_2222, 4'hC);
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({rsp_valid, rsp_err, rsp_dat, cmd_ready, wb_cyc_o} !== {2'b10, 32'h55AA_33CC, 2'b00}) begin
        bad++; $display("FAIL backpressure cyc%0d got v=%b err=%b dat=%h rdy=%b cyc=%b", i, rsp_valid, rsp_err,
                        rsp_dat, cmd_ready, wb_cyc_o);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if ({cmd_ready, rsp_valid, wb_cyc_o} !== 3'b100) begin
      bad++; $display("FAIL bp_release got rdy=%b v=%b cyc=%b exp 1,0,0", cmd_ready, rsp_valid, wb_cyc_o);
    end
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== {2'b11, 32'h2400_0010, 32'h1111_2222, 4'hC}) begin
      bad++; $display("FAIL bp_next_cmd got cyc=%b we=%b adr=%h dat=%h sel=%h", wb_cyc_o, wb_we_o, wb_adr_o,
                      wb_dat_o, wb_sel_o);
    end
    ack_man  = 1'b1;
    wb_dat_i = 32'hFFFF_FFFF;
    tick();
    ack_man = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [5:0] cyc_pat, v_pat, rdy_pat;
    cyc_pat = 6'b100100;
    v_pat   = 6'b010010;
    rdy_pat = 6'b001001;
    ack_follow = 1'b1;
    rsp_ready  = 1'b1;
    wb_dat_i   = 32'h600D_CAFE;
    drive_cmd(1'b0, 32'h2400_0014, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if ({wb_cyc_o, rsp_valid, cmd_ready} !== {cyc_pat[5-i], v_pat[5-i], rdy_pat[5-i]}) begin
        bad++; $display("FAIL b2b_timing cyc%0d got cyc=%b v=%b rdy=%b exp %b%b%b", i, wb_cyc_o, rsp_valid,
                        cmd_ready, cyc_pat[5-i], v_pat[5-i], rdy_pat[5-i]);
      end
      if (v_pat[5-i]) begin
        total++;
        if (rsp_dat !== 32'h600D_CAFE) begin
          bad++; $display("FAIL b2b_data cyc%0d got=%h exp=600dcafe", i, rsp_dat);
        end
      end
    end
    cmd_valid  = 1'b0;
    ack_follow = 1'b0;
    rsp_ready  = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_bus;
    int seen;
    drive_cmd(1'b0, 32'h2400_0018, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    tick();
    total++;
    if (wb_stb_o !== 1'b1) begin bad++; $display("FAIL midbus_pre got stb=%b exp=1", wb_stb_o); end
    rst = 1'b1;
    tick();
    total++;
    if ({wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready, wb_adr_o} !== {4'b0000, 32'h0}) begin
      bad++; $display("FAIL midbus_reset got cyc=%b stb=%b v=%b rdy=%b adr=%h", wb_cyc_o, wb_stb_o, rsp_valid,
                      cmd_ready, wb_adr_o);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midbus_ready got=%b exp=1", cmd_ready); end
    seen = 0;
    ack_man = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid === 1'b1 || wb_cyc_o === 1'b1) seen++;
    end
    ack_man = 1'b0;
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midbus_no_rsp got=%0d activity cycles exp=0", seen); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0; cmd_sel = 4'h0;
    rsp_ready = 1'b0; wb_dat_i = 32'h0; ack_man = 1'b0; ack_follow = 1'b0;
    cmd_valid2 = 1'b0; cmd_we2 = 1'b0; cmd_adr2 = 32'h0; cmd_dat2 = 32'h0; cmd_sel2 = 4'h0;
    rsp_ready2 = 1'b0; wb_dat_i2 = 32'h0; wb_ack_i2 = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait3();
    test_timeout();
    test_ack_on_expiry();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_bus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
